image_binarize_stream: RTL and testbench



---
 rtl/img_pkg.sv | 22 ++
 rtl/stream_skid_buf.sv | 52 +++++
 rtl/image_binarize_stream.sv | 134 +++++++++++++
 tb/tb_image_binarize_stream.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared types and geometry for the binarization pipeline stages.
package img_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int IMG_WIDTH  = 1920;
  localparam int IMG_HEIGHT = 1080;

  typedef struct packed {
    logic bit_val;
    logic sof;
    logic eol;
    logic eof;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready skid buffer; one cycle from accept to out_valid.
// in_ready depends only on occupancy, so a full buffer simply stalls upstream.
module stream_skid_buf #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/image_binarize_stream.sv
// Raster-order grayscale to binary stream with sof/eol/eof markers and resync on early sof.
// One cycle latency through a 2-entry skid buffer; in_ready drops only when that buffer is full.
module image_binarize_stream
  import img_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] cfg_thr,
  input  logic             cfg_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             err_resync,
  output logic [15:0]      frame_cnt
);

  // Width 1 keeps the counters legal for degenerate 1-pixel geometries.
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  state_t           state, state_nxt;
  logic [XW-1:0]    x, x_nxt, x_cur;
  logic [YW-1:0]    y, y_nxt, y_cur;
  logic [PIX_W-1:0] thr, thr_nxt, thr_use;
  logic             inv, inv_nxt, inv_use;
  logic             accept;
  logic             emit;
  logic             resync_nxt;
  logic             frame_done;
  beat_t            beat;
  beat_t            out_beat;
  logic [BEAT_W-1:0] buf_data;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    x_nxt      = x;
    y_nxt      = y;
    thr_nxt    = thr;
    inv_nxt    = inv;
    emit       = 1'b0;
    resync_nxt = 1'b0;
    frame_done = 1'b0;

    // A sof pixel uses the freshly sampled config and restarts the raster itself.
    thr_use = in_sof ? cfg_thr : thr;
    inv_use = in_sof ? cfg_inv : inv;
    x_cur   = in_sof ? '0 : x;
    y_cur   = in_sof ? '0 : y;

    beat.bit_val = (in_pix <= thr_use) ^ inv_use;
    beat.sof     = in_sof;
    beat.eol     = (x_cur == X_LAST);
    beat.eof     = (x_cur == X_LAST) && (y_cur == Y_LAST);

    if (accept && (in_sof || state == ACTIVE)) begin
      emit       = 1'b1;
      thr_nxt    = thr_use;
      inv_nxt    = inv_use;
      resync_nxt = in_sof && (state == ACTIVE);
      if (beat.eof) begin
        x_nxt      = '0;
        y_nxt      = '0;
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end else if (beat.eol) begin
        x_nxt     = '0;
        y_nxt     = y_cur + YW'(1);
        state_nxt = ACTIVE;
      end else begin
        x_nxt     = x_cur + XW'(1);
        y_nxt     = y_cur;
        state_nxt = ACTIVE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      thr        <= '0;
      inv        <= 1'b0;
      err_resync <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      x          <= x_nxt;
      y          <= y_nxt;
      thr        <= thr_nxt;
      inv        <= inv_nxt;
      err_resync <= resync_nxt;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  stream_skid_buf #(
    .W(BEAT_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (emit),
    .in_ready (in_ready),
    .in_data  (beat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_data)
  );

  assign out_beat = buf_data;
  assign out_bit  = out_beat.bit_val;
  assign out_sof  = out_beat.sof;
  assign out_eol  = out_beat.eol;
  assign out_eof  = out_beat.eof;

endmodule

// File: tb/tb_image_binarize_stream.sv
// Directed bench: 4x2 frames through the main instance, plus a 1x1 instance for the degenerate case.
module tb_image_binarize_stream;

  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sof, cfg_inv;
  logic [7:0]  in_pix, cfg_thr;
  logic        out_valid, out_ready, out_bit, out_sof, out_eol, out_eof, err_resync;
  logic [15:0] frame_cnt;

  logic        d_in_valid, d_in_ready, d_in_sof, d_cfg_inv;
  logic [7:0]  d_in_pix, d_cfg_thr;
  logic        d_out_valid, d_out_bit, d_out_sof, d_out_eol, d_out_eof, d_err_resync;
  logic [15:0] d_frame_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  image_binarize_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_sof(in_sof),
    .cfg_thr(cfg_thr), .cfg_inv(cfg_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .err_resync(err_resync), .frame_cnt(frame_cnt)
  );

  image_binarize_stream #(.WIDTH(1), .HEIGHT(1), .PIX_W(8)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_pix(d_in_pix), .in_sof(d_in_sof),
    .cfg_thr(d_cfg_thr), .cfg_inv(d_cfg_inv),
    .out_valid(d_out_valid), .out_ready(1'b1), .out_bit(d_out_bit),
    .out_sof(d_out_sof), .out_eol(d_out_eol), .out_eof(d_out_eof),
    .err_resync(d_err_resync), .frame_cnt(d_frame_cnt)
  );

  typedef struct {
    logic [7:0]  pix;
    logic        sof;
    logic [7:0]  thr;
    logic        inv;
    logic        vld;
    logic        b;
    logic        s;
    logic        e;
    logic        f;
    logic        err;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[$];
  int   bp_pix[4] = '{0, 255, 10, 20};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void add(input logic [7:0] pix, input logic sof, input logic [7:0] thr,
                              input logic inv, input logic vld, input logic b, input logic s,
                              input logic e, input logic f, input logic err, input logic [15:0] fc);
    vec_t v;
    v.pix = pix; v.sof = sof; v.thr = thr; v.inv = inv; v.vld = vld;
    v.b = b; v.s = s; v.e = e; v.f = f; v.err = err; v.fc = fc;
    vecs.push_back(v);
  endfunction

  // One pixel per call: drive on negedge, accept on posedge, check the beat on the following negedge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_pix = v.pix; in_sof = v.sof; cfg_thr = v.thr; cfg_inv = v.inv;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;
    @(negedge clk);
    check({tag, "_vld"}, out_valid, v.vld);
    if (v.vld) begin
      check({tag, "_bit"}, out_bit, v.b);
      check({tag, "_sof"}, out_sof, v.s);
      check({tag, "_eol"}, out_eol, v.e);
      check({tag, "_eof"}, out_eof, v.f);
    end
    check({tag, "_err"}, err_resync, v.err);
    check({tag, "_fcnt"}, frame_cnt, v.fc);
  endtask

  initial begin
    int   k;
    int   got;
    logic acc;
    logic got_bit [3];
    logic got_sof [3];
    vec_t v;

    rst = 1'b1; in_valid = 1'b0; in_pix = '0; in_sof = 1'b0; cfg_thr = '0; cfg_inv = 1'b0;
    out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_pix = '0; d_in_sof = 1'b0; d_cfg_thr = '0; d_cfg_inv = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_fields", {out_bit, out_sof, out_eol, out_eof}, 0);
    check("rst_err", err_resync, 0);
    check("rst_fcnt", frame_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Frame A: thr=100, inv=0
    add(8'd0,   1, 100, 0, 1, 1, 1, 0, 0, 0, 0);
    add(8'd100, 0, 100, 0, 1, 1, 0, 0, 0, 0, 0);
    add(8'd101, 0, 100, 0, 1, 0, 0, 0, 0, 0, 0);
    add(8'd255, 0, 100, 0, 1, 0, 0, 1, 0, 0, 0);
    add(8'd50,  0, 100, 0, 1, 1, 0, 0, 0, 0, 0);
    add(8'd150, 0, 100, 0, 1, 0, 0, 0, 0, 0, 0);
    add(8'd99,  0, 100, 0, 1, 1, 0, 0, 0, 0, 0);
    add(8'd200, 0, 100, 0, 1, 0, 0, 1, 1, 0, 1);
    // Frame B: inv=1 at sof, cfg changed mid-frame must be ignored
    add(8'd0,   1, 100, 1, 1, 0, 1, 0, 0, 0, 1);
    add(8'd100, 0, 0,   0, 1, 0, 0, 0, 0, 0, 1);
    add(8'd101, 0, 0,   0, 1, 1, 0, 0, 0, 0, 1);
    add(8'd255, 0, 0,   0, 1, 1, 0, 1, 0, 0, 1);
    add(8'd50,  0, 0,   0, 1, 0, 0, 0, 0, 0, 1);
    add(8'd150, 0, 0,   0, 1, 1, 0, 0, 0, 0, 1);
    add(8'd99,  0, 0,   0, 1, 0, 0, 0, 0, 0, 1);
    add(8'd200, 0, 0,   0, 1, 1, 0, 1, 1, 0, 2);
    // IDLE discards, then frame C with an early sof on its 3rd pixel
    add(8'd10,  0, 100, 0, 0, 0, 0, 0, 0, 0, 2);
    add(8'd20,  0, 100, 0, 0, 0, 0, 0, 0, 0, 2);
    add(8'd200, 1, 100, 0, 1, 0, 1, 0, 0, 0, 2);
    add(8'd30,  0, 100, 0, 1, 1, 0, 0, 0, 0, 2);
    add(8'd60,  1, 50,  0, 1, 0, 1, 0, 0, 1, 2);
    add(8'd40,  0, 100, 0, 1, 1, 0, 0, 0, 0, 2);
    add(8'd70,  0, 100, 0, 1, 0, 0, 0, 0, 0, 2);
    add(8'd50,  0, 100, 0, 1, 1, 0, 1, 0, 0, 2);
    add(8'd51,  0, 100, 0, 1, 0, 0, 0, 0, 0, 2);
    add(8'd0,   0, 100, 0, 1, 1, 0, 0, 0, 0, 2);
    add(8'd255, 0, 100, 0, 1, 0, 0, 0, 0, 0, 2);
    add(8'd49,  0, 100, 0, 1, 1, 0, 1, 1, 0, 3);

    // 1x1 geometry: a single pixel is the whole frame
    @(negedge clk);
    d_in_valid = 1'b1; d_in_sof = 1'b1; d_in_pix = 8'd7; d_cfg_thr = 8'd7;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0; d_in_sof = 1'b0;
    @(negedge clk);
    check("deg_vld", d_out_valid, 1);
    check("deg_fields", {d_out_bit, d_out_sof, d_out_eol, d_out_eof}, 4'b1111);
    check("deg_fcnt", d_frame_cnt, 1);
    check("deg_err", d_err_resync, 0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Backpressure: out_ready low for 5 cycles with in_valid held
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; cfg_thr = 8'd100; cfg_inv = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      in_pix = bp_pix[k % 4][7:0];
      in_sof = (k == 0);
      acc = in_ready;
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
      if (c >= 2) check($sformatf("bp_hold%0d", c), {out_valid, out_bit, out_sof}, 3'b111);
    end
    check("bp_accepts", k, 2);
    check("bp_in_ready", in_ready, 0);
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      if (out_valid) begin
        got_bit[got] = out_bit;
        got_sof[got] = out_sof;
        got++;
      end
      @(negedge clk);
    end
    check("bp_beats", got, 2);
    check("bp_beat0", {got_bit[0], got_sof[0]}, 2'b11);
    check("bp_beat1", {got_bit[1], got_sof[1]}, 2'b00);
    check("bp_drained", out_valid, 0);

    // Reset mid-frame with a beat held in the buffer
    out_ready = 1'b0;
    in_valid = 1'b1; in_pix = 8'd5; in_sof = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_vld", out_valid, 1);
    check("pre_rst_fcnt", frame_cnt, 3);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_vld", out_valid, 0);
    check("rst_mid_fcnt", frame_cnt, 0);
    check("rst_mid_rdy", in_ready, 1);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    v = '{pix: 8'd10, sof: 1'b0, thr: 8'd100, inv: 1'b0, vld: 1'b0, b: 1'b0, s: 1'b0,
          e: 1'b0, f: 1'b0, err: 1'b0, fc: 16'd0};
    apply(v, "post_rst_idle");
    v = '{pix: 8'd100, sof: 1'b1, thr: 8'd100, inv: 1'b0, vld: 1'b1, b: 1'b1, s: 1'b1,
          e: 1'b0, f: 1'b0, err: 1'b0, fc: 16'd0};
    apply(v, "post_rst_sof");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
